// File: rtl/clock_pkg.sv
// Shared constants and types for the digital clock timekeeping path.
package clock_pkg;

    localparam int unsigned SEC_W = 6;
    localparam int unsigned MIN_W = 6;
    localparam int unsigned HR_W  = 5;

    localparam int unsigned SEC_MAX = 59;
    localparam int unsigned MIN_MAX = 59;
    localparam int unsigned HR_MAX  = 23;

    typedef enum logic [1:0] {
        MODE_RUN     = 2'b00,
        MODE_SET_HR  = 2'b01,
        MODE_SET_MIN = 2'b10,
        MODE_ILLEGAL = 2'b11
    } mode_e;

endpackage

// File: rtl/mod_counter.sv
// Modulo-(MAX+1) counter with synchronous clear; tc flags the wrapping increment.
module mod_counter #(
    parameter int unsigned WIDTH = 6,
    parameter int unsigned MAX   = 59
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    output logic [WIDTH-1:0] q,
    output logic             tc
);

    logic [WIDTH-1:0] cnt_q;
    logic             at_max;

    // Exact equality detect; values above MAX are never produced.
    assign at_max = (cnt_q == WIDTH'(MAX));
    assign tc     = en & at_max;
    assign q      = cnt_q;

    // Clear has priority over increment; wrap to 0 after MAX.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (en) begin
            cnt_q <= at_max ? '0 : cnt_q + WIDTH'(1);
        end
    end

endmodule

// File: rtl/clock_time_ctrl.sv
// Timekeeping controller: 1 Hz prescaler, sec/min/hr carry chain and button set modes.
module clock_time_ctrl
    import clock_pkg::*;
#(
    parameter int unsigned TICKS_PER_SEC = 50000000,
    parameter int unsigned PRESC_W       = 26
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run_en,
    input  logic             mode_btn,
    input  logic             inc_btn,
    output logic [SEC_W-1:0] sec,
    output logic [MIN_W-1:0] min,
    output logic [HR_W-1:0]  hr,
    output logic [1:0]       mode,
    output logic             blink,
    output logic             sec_tick
);

    mode_e              mode_q;
    logic [PRESC_W-1:0] presc_q;
    logic [PRESC_W-1:0] presc_next;
    logic               blink_q;
    logic               sec_tick_q;

    logic in_run;
    logic in_set_hr;
    logic in_set_min;
    logic presc_wrap;
    logic tick;
    logic inc_ok;
    logic sec_clr;
    logic sec_tc;
    logic min_en;
    logic min_tc;
    logic hr_en;
    logic unused_hr_tc;

    assign in_run     = (mode_q == MODE_RUN);
    assign in_set_hr  = (mode_q == MODE_SET_HR);
    assign in_set_min = (mode_q == MODE_SET_MIN);
    assign presc_wrap = (presc_q == PRESC_W'(TICKS_PER_SEC - 1));
    assign presc_next = presc_wrap ? '0 : presc_q + PRESC_W'(1);

    // A tick coinciding with mode_btn is dropped; mode_btn also masks inc_btn.
    assign tick    = in_run & run_en & presc_wrap & ~mode_btn;
    assign inc_ok  = inc_btn & ~mode_btn;
    assign sec_clr = in_run & mode_btn;

    // Carries only propagate in RUN; set-mode increments wrap within their own field.
    assign min_en = (in_run & sec_tc) | (in_set_min & inc_ok);
    assign hr_en  = (in_run & min_tc) | (in_set_hr & inc_ok);

    mod_counter #(
        .WIDTH (SEC_W),
        .MAX   (SEC_MAX)
    ) u_sec (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (sec_clr),
        .en    (tick),
        .q     (sec),
        .tc    (sec_tc)
    );

    mod_counter #(
        .WIDTH (MIN_W),
        .MAX   (MIN_MAX)
    ) u_min (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (1'b0),
        .en    (min_en),
        .q     (min),
        .tc    (min_tc)
    );

    mod_counter #(
        .WIDTH (HR_W),
        .MAX   (HR_MAX)
    ) u_hr (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (1'b0),
        .en    (hr_en),
        .q     (hr),
        .tc    (unused_hr_tc)
    );

    // Mode FSM, prescaler, blink and registered tick pulse.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mode_q     <= MODE_RUN;
            presc_q    <= '0;
            blink_q    <= 1'b0;
            sec_tick_q <= 1'b0;
        end else begin
            sec_tick_q <= tick;
            case (mode_q)
                MODE_RUN: begin
                    if (mode_btn) begin
                        mode_q  <= MODE_SET_HR;
                        presc_q <= '0;
                        blink_q <= 1'b1;
                    end else begin
                        blink_q <= 1'b0;
                        if (run_en) begin
                            presc_q <= presc_next;
                        end
                    end
                end
                MODE_SET_HR: begin
                    if (mode_btn) begin
                        mode_q  <= MODE_SET_MIN;
                        presc_q <= '0;
                        blink_q <= 1'b1;
                    end else begin
                        presc_q <= presc_next;
                        if (presc_wrap) begin
                            blink_q <= ~blink_q;
                        end
                    end
                end
                MODE_SET_MIN: begin
                    // Restarting the prescaler gives a full second before the first increment.
                    if (mode_btn) begin
                        mode_q  <= MODE_RUN;
                        presc_q <= '0;
                        blink_q <= 1'b0;
                    end else begin
                        presc_q <= presc_next;
                        if (presc_wrap) begin
                            blink_q <= ~blink_q;
                        end
                    end
                end
                default: begin
                    mode_q <= MODE_RUN;
                end
            endcase
        end
    end

    assign mode     = mode_q;
    assign blink    = blink_q;
    assign sec_tick = sec_tick_q;

endmodule

// File: tb/tb_clock_time_ctrl.sv
// Bench for clock_time_ctrl: seconds-of-day reference model plus literal spot checks.
module tb_clock_time_ctrl;

    localparam int TPS = 4;

    logic       clk;
    logic       rst_n;
    logic       run_en;
    logic       mode_btn;
    logic       inc_btn;
    logic [5:0] sec;
    logic [5:0] min;
    logic [4:0] hr;
    logic [1:0] mode;
    logic       blink;
    logic       sec_tick;

    int n_cmp;
    int n_bad;

    // Reference state: time of day in seconds, mode number, cycles into current second.
    int tod;
    int m_mode;
    int m_phase;
    int m_blink;
    int m_tick;

    clock_time_ctrl #(
        .TICKS_PER_SEC (TPS),
        .PRESC_W       (3)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .run_en   (run_en),
        .mode_btn (mode_btn),
        .inc_btn  (inc_btn),
        .sec      (sec),
        .min      (min),
        .hr       (hr),
        .mode     (mode),
        .blink    (blink),
        .sec_tick (sec_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_edge(input logic r, input logic re, input logic mb, input logic ib);
        int wrap;
        int h;
        int m;
        if (!r) begin
            tod = 0; m_mode = 0; m_phase = 0; m_blink = 0; m_tick = 0;
        end else begin
            wrap   = (m_phase == TPS - 1) ? 1 : 0;
            m_tick = 0;
            if (m_mode == 0) begin
                if (mb) begin
                    m_mode = 1; tod = tod - (tod % 60); m_phase = 0; m_blink = 1;
                end else begin
                    m_blink = 0;
                    if (re) begin
                        if (wrap != 0) begin
                            m_phase = 0; tod = (tod + 1) % 86400; m_tick = 1;
                        end else begin
                            m_phase++;
                        end
                    end
                end
            end else begin
                if (mb) begin
                    m_mode  = (m_mode == 1) ? 2 : 0;
                    m_phase = 0;
                    m_blink = (m_mode == 2) ? 1 : 0;
                end else begin
                    if (ib) begin
                        h = tod / 3600;
                        m = (tod / 60) % 60;
                        if (m_mode == 1) tod = tod + (((h + 1) % 24) - h) * 3600;
                        else             tod = tod + (((m + 1) % 60) - m) * 60;
                    end
                    if (wrap != 0) begin
                        m_phase = 0; m_blink = 1 - m_blink;
                    end else begin
                        m_phase++;
                    end
                end
            end
        end
    endtask

    // One clock: drive inputs, update the model on the edge, compare #1 later.
    task automatic step(input logic r, input logic re, input logic mb, input logic ib);
        rst_n = r; run_en = re; mode_btn = mb; inc_btn = ib;
        @(posedge clk);
        model_edge(r, re, mb, ib);
        #1;
        n_cmp++;
        if (int'(sec) != tod % 60 || int'(min) != (tod / 60) % 60 || int'(hr) != tod / 3600 ||
            int'(mode) != m_mode || int'(blink) != m_blink || int'(sec_tick) != m_tick) begin
            n_bad++;
            $display("FAIL cycle@%0t: got %0d:%0d:%0d mode=%0d blink=%0d tick=%0d, want %0d:%0d:%0d mode=%0d blink=%0d tick=%0d",
                     $time, hr, min, sec, mode, blink, sec_tick,
                     tod / 3600, (tod / 60) % 60, tod % 60, m_mode, m_blink, m_tick);
        end
    endtask

    task automatic check_lit(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic run_n(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic inc_n(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b1, 1'b0, 1'b1);
    endtask

    initial begin
        n_cmp = 0; n_bad = 0;
        tod = 0; m_mode = 0; m_phase = 0; m_blink = 0; m_tick = 0;
        rst_n = 1'b0; run_en = 1'b0; mode_btn = 1'b0; inc_btn = 1'b0;

        // Reset
        step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b1);
        check_lit("reset_sec", int'(sec), 0);
        check_lit("reset_mode", int'(mode), 0);
        check_lit("reset_blink", int'(blink), 0);

        // First second after reset release
        run_n(3);
        check_lit("pre_tick_sec", int'(sec), 0);
        run_n(1);
        check_lit("tick4_sec", int'(sec), 1);
        check_lit("tick4_pulse", int'(sec_tick), 1);
        run_n(1);
        check_lit("tick_width", int'(sec_tick), 0);
        run_n(3);
        check_lit("tick8_sec", int'(sec), 2);

        // Freeze: prescaler holds at 0 and resumes
        for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
        check_lit("freeze_sec", int'(sec), 2);
        run_n(3);
        check_lit("resume_pre", int'(sec), 2);
        run_n(1);
        check_lit("resume_sec", int'(sec), 3);

        // Set hours: 25 increments from 0 -> 1
        step(1'b1, 1'b1, 1'b1, 1'b0);
        check_lit("sethr_mode", int'(mode), 1);
        check_lit("sethr_sec_clr", int'(sec), 0);
        check_lit("sethr_blink", int'(blink), 1);
        for (int i = 0; i < 25; i++) begin
            step(1'b1, 1'b1, 1'b0, 1'b1);
            if (i == 3) check_lit("blink_toggle4", int'(blink), 0);
        end
        check_lit("hr_after25", int'(hr), 1);
        check_lit("min_untouched", int'(min), 0);
        check_lit("blink_after25", int'(blink), 1);

        // mode_btn beats inc_btn at hr=5
        inc_n(4);
        step(1'b1, 1'b1, 1'b1, 1'b1);
        check_lit("simul_mode", int'(mode), 2);
        check_lit("simul_hr", int'(hr), 5);

        // Set minutes: 59 wraps to 0 without carry into hours
        inc_n(59);
        check_lit("min59", int'(min), 59);
        inc_n(1);
        check_lit("min_wrap", int'(min), 0);
        check_lit("min_wrap_hr", int'(hr), 5);
        inc_n(59);
        step(1'b1, 1'b1, 1'b1, 1'b0);
        check_lit("back_run", int'(mode), 0);

        // Hours to 23, back to RUN at 23:59:00
        step(1'b1, 1'b1, 1'b1, 1'b0);
        inc_n(18);
        check_lit("hr23", int'(hr), 23);
        step(1'b1, 1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 59 * TPS; i++) begin
            step(1'b1, 1'b1, 1'b0, 1'b0);
            if (i == 2) check_lit("restart_pre", int'(sec), 0);
            if (i == 3) check_lit("restart_first", int'(sec), 1);
        end
        check_lit("pre_roll_sec", int'(sec), 59);
        check_lit("pre_roll_min", int'(min), 59);
        check_lit("pre_roll_hr", int'(hr), 23);
        run_n(TPS);
        check_lit("roll_sec", int'(sec), 0);
        check_lit("roll_min", int'(min), 0);
        check_lit("roll_hr", int'(hr), 0);
        check_lit("roll_tick", int'(sec_tick), 1);

        // Reset mid-operation in SET_MIN at 12:34
        step(1'b1, 1'b1, 1'b1, 1'b0);
        inc_n(12);
        step(1'b1, 1'b1, 1'b1, 1'b0);
        inc_n(34);
        check_lit("pre_rst_hr", int'(hr), 12);
        check_lit("pre_rst_min", int'(min), 34);
        check_lit("pre_rst_mode", int'(mode), 2);
        step(1'b0, 1'b1, 1'b0, 1'b1);
        check_lit("midrst_hr", int'(hr), 0);
        check_lit("midrst_min", int'(min), 0);
        check_lit("midrst_mode", int'(mode), 0);
        check_lit("midrst_blink", int'(blink), 0);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b1, 1'b0, 1'b0);
            check_lit("post_rst_notick", int'(sec_tick), 0);
        end
        run_n(1);
        check_lit("post_rst_sec", int'(sec), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
